// File: rtl/desppunch_pkg.sv
// Shared types and constants for the desperation-punch animation block.
package desppunch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    COOLDOWN = 2'd2
  } anim_state_t;

  localparam logic [3:0]  TRANSPARENT_IDX = 4'h0;
  localparam int unsigned SCREEN_W        = 640;
  localparam int unsigned SCREEN_H        = 480;
  localparam int unsigned COORD_W         = 10;

  // Counter width that never collapses to zero bits for tiny parameter values.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/desppunch_seq.sv
// Punch animation sequencer: IDLE/PLAY/COOLDOWN FSM, frame and hold counters,
// request latch and per-video-frame position latch. Advances only on frame_tick.
module desppunch_seq
  import desppunch_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned HOLD_TICKS = 5,
  parameter int unsigned COOL_TICKS = 8,
  parameter int unsigned HIT_FRAME  = 2,
  parameter int unsigned FRAME_W    = clog2_min1(NUM_FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               punch_req,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               facing_left,
  output logic [COORD_W-1:0] lat_x,
  output logic [COORD_W-1:0] lat_y,
  output logic               lat_left,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               busy,
  output logic               hit_active
);

  localparam int unsigned HOLD_W = clog2_min1(HOLD_TICKS);
  localparam int unsigned COOL_W = clog2_min1(COOL_TICKS);

  anim_state_t       state;
  logic [HOLD_W-1:0] hold;
  logic [COOL_W-1:0] cnt;
  logic              pending;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      anim_frame <= '0;
      hold       <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_left   <= 1'b0;
      busy       <= 1'b0;
      hit_active <= 1'b0;
    end else begin
      // A request seen between ticks is remembered until the next tick starts the move.
      if (state == IDLE && punch_req) pending <= 1'b1;

      if (frame_tick) begin
        lat_x    <= pos_x;
        lat_y    <= pos_y;
        lat_left <= facing_left;

        unique case (state)
          IDLE: begin
            anim_frame <= '0;
            if (pending || punch_req) begin
              state      <= PLAY;
              hold       <= '0;
              pending    <= 1'b0;
              busy       <= 1'b1;
              hit_active <= (HIT_FRAME == 0);
            end
          end
          PLAY: begin
            if (hold == HOLD_W'(HOLD_TICKS - 1)) begin
              hold <= '0;
              if (anim_frame == FRAME_W'(NUM_FRAMES - 1)) begin
                state      <= COOLDOWN;
                cnt        <= '0;
                hit_active <= 1'b0;
              end else begin
                anim_frame <= anim_frame + FRAME_W'(1);
                hit_active <= ((anim_frame + FRAME_W'(1)) == FRAME_W'(HIT_FRAME));
              end
            end else begin
              hold <= hold + HOLD_W'(1);
            end
          end
          COOLDOWN: begin
            if (cnt == COOL_W'(COOL_TICKS - 1)) begin
              state      <= IDLE;
              anim_frame <= '0;
              busy       <= 1'b0;
            end else begin
              cnt <= cnt + COOL_W'(1);
            end
          end
          default: begin
            state      <= IDLE;
            busy       <= 1'b0;
            hit_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/desppunch_anim.sv
// Desperation-punch sprite: sequencer plus a 2-stage DrawX/DrawY -> ROM -> palette-index pipeline.
module desppunch_anim
  import desppunch_pkg::*;
#(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 96,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned HOLD_TICKS = 5,
  parameter int unsigned COOL_TICKS = 8,
  parameter int unsigned HIT_FRAME  = 2,
  parameter int unsigned ADDR_W     = $clog2(NUM_FRAMES * SPR_W * SPR_H),
  localparam int unsigned FRAME_W   = clog2_min1(NUM_FRAMES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               punch_req,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               facing_left,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_q,
  output logic [3:0]         palette_index,
  output logic               sprite_on,
  output logic               busy,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               hit_active
);

  localparam int unsigned DIFF_W = COORD_W + 1;

  logic [COORD_W-1:0] lat_x;
  logic [COORD_W-1:0] lat_y;
  logic               lat_left;

  desppunch_seq #(
    .NUM_FRAMES (NUM_FRAMES),
    .HOLD_TICKS (HOLD_TICKS),
    .COOL_TICKS (COOL_TICKS),
    .HIT_FRAME  (HIT_FRAME),
    .FRAME_W    (FRAME_W)
  ) u_seq (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .punch_req   (punch_req),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .facing_left (facing_left),
    .lat_x       (lat_x),
    .lat_y       (lat_y),
    .lat_left    (lat_left),
    .anim_frame  (anim_frame),
    .busy        (busy),
    .hit_active  (hit_active)
  );

  logic [DIFF_W-1:0] dx;
  logic [DIFF_W-1:0] dy;
  logic              in_box;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr;

  // Offsets are two's complement; bit DIFF_W-1 set means the pixel is left of/above the box.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, lat_x};
    dy     = {1'b0, DrawY} - {1'b0, lat_y};
    in_box = !dx[DIFF_W-1] && (dx < DIFF_W'(SPR_W)) &&
             !dy[DIFF_W-1] && (dy < DIFF_W'(SPR_H));
    col    = lat_left ? (ADDR_W'(SPR_W - 1) - ADDR_W'(dx)) : ADDR_W'(dx);
    addr   = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H)
           + ADDR_W'(dy) * ADDR_W'(SPR_W) + col;
  end

  logic in_box_q;
  logic in_box_qq;

  // Stage 1 issues the ROM address; the in-box flag rides along to meet rom_q one cycle later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr      <= '0;
      in_box_q      <= 1'b0;
      in_box_qq     <= 1'b0;
      palette_index <= TRANSPARENT_IDX;
      sprite_on     <= 1'b0;
    end else begin
      rom_addr  <= in_box ? addr : '0;
      in_box_q  <= in_box;
      in_box_qq <= in_box_q;
      if (in_box_qq && (rom_q != TRANSPARENT_IDX)) begin
        palette_index <= rom_q;
        sprite_on     <= 1'b1;
      end else begin
        palette_index <= TRANSPARENT_IDX;
        sprite_on     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_desppunch_anim.sv
// Directed bench for desppunch_anim: sequencer timing, pixel vectors, streaming pipeline, reset.
module tb_desppunch_anim;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic        punch_req;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        facing_left;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  palette_index;
  logic        sprite_on;
  logic        busy;
  logic [1:0]  anim_frame;
  logic        hit_active;

  int errors = 0;
  int checks = 0;

  logic       rom_stream = 1'b0;
  logic [3:0] rom_fix    = 4'h0;

  always #5 Clk = ~Clk;

  // Synchronous ROM stand-in: either a fixed value or the address low nibble.
  always @(posedge Clk) rom_q <= rom_stream ? rom_addr[3:0] : rom_fix;

  desppunch_anim dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .punch_req     (punch_req),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .facing_left   (facing_left),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .rom_addr      (rom_addr),
    .rom_q         (rom_q),
    .palette_index (palette_index),
    .sprite_on     (sprite_on),
    .busy          (busy),
    .anim_frame    (anim_frame),
    .hit_active    (hit_active)
  );

  typedef struct {
    int px;
    int py;
    int left;
    int x;
    int y;
    int rq;
    int e_addr;
    int e_idx;
    int e_on;
  } pix_vec_t;

  pix_vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  function automatic int stream_x(input int i);
    return (i < 10) ? 95 + i : 150 + i;
  endfunction

  initial begin
    int lat_px, lat_py, lat_left;
    int dxm, e_addr, e_idx;
    int sx[20];

    vecs[0] = '{100, 50, 0, 103,  52, 7,  6275, 7, 1};
    vecs[1] = '{100, 50, 0, 103,  52, 0,  6275, 0, 0};
    vecs[2] = '{100, 50, 0, 163, 145, 5, 12287, 5, 1};
    vecs[3] = '{100, 50, 0, 163, 146, 5,     0, 0, 0};
    vecs[4] = '{100, 50, 0,  99,  52, 5,     0, 0, 0};
    vecs[5] = '{100, 50, 1, 103,  52, 7,  6332, 7, 1};
    vecs[6] = '{100, 50, 1, 100,  50, 9,  6207, 9, 1};
    vecs[7] = '{100, 50, 1, 164,  52, 7,     0, 0, 0};
    vecs[8] = '{600, 50, 0,  10,  52, 7,     0, 0, 0};
    vecs[9] = '{600, 50, 0, 639,  52, 3,  6311, 3, 1};

    Reset = 1'b1; frame_tick = 1'b0; punch_req = 1'b0;
    pos_x = '0; pos_y = '0; facing_left = 1'b0; DrawX = '0; DrawY = '0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame", int'(anim_frame), 0);
    chk("rst_hit", int'(hit_active), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_idx", int'(palette_index), 0);
    chk("rst_on", int'(sprite_on), 0);
    Reset = 1'b0;

    // One-cycle request between ticks, then a full move
    pos_x = 10'd100; pos_y = 10'd50;
    @(negedge Clk) punch_req = 1'b1;
    @(negedge Clk) punch_req = 1'b0;
    repeat (2) @(negedge Clk);
    chk("b1_wait_busy", int'(busy), 0);
    tick();
    chk("b1_start_busy", int'(busy), 1);
    chk("b1_start_frame", int'(anim_frame), 0);
    for (int t = 1; t <= 32; t++) begin
      tick();
      chk($sformatf("b1_busy_t%0d", t), int'(busy), (t < 28) ? 1 : 0);
      if (t < 20) begin
        chk($sformatf("b1_frame_t%0d", t), int'(anim_frame), t / 5);
        chk($sformatf("b1_hit_t%0d", t), int'(hit_active), (t / 5 == 2) ? 1 : 0);
      end else if (t >= 28) begin
        chk($sformatf("b1_idle_frame_t%0d", t), int'(anim_frame), 0);
      end else begin
        chk($sformatf("b1_cool_hit_t%0d", t), int'(hit_active), 0);
      end
    end

    // Request held through the move: ignored until IDLE, then retriggers on the next tick
    @(negedge Clk) punch_req = 1'b1;
    tick();
    chk("b2_start_busy", int'(busy), 1);
    for (int t = 1; t <= 29; t++) begin
      tick();
      chk($sformatf("b2_busy_t%0d", t), int'(busy), (t == 28) ? 0 : 1);
    end
    punch_req = 1'b0;
    chk("b2_retrig_frame", int'(anim_frame), 0);
    repeat (10) tick();
    chk("b2_frame2", int'(anim_frame), 2);
    chk("b2_hit", int'(hit_active), 1);

    // Reset mid-move at frame 2
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_frame", int'(anim_frame), 0);
    chk("mid_rst_hit", int'(hit_active), 0);
    chk("mid_rst_on", int'(sprite_on), 0);
    Reset = 1'b0;
    tick();
    chk("mid_rst_stays_idle", int'(busy), 0);

    // Pending request is discarded by reset
    @(negedge Clk) punch_req = 1'b1;
    @(negedge Clk) punch_req = 1'b0;
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    tick();
    chk("no_residual_pending", int'(busy), 0);

    // Tick and request in the same cycle start the move on that edge
    pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
    @(negedge Clk) begin punch_req = 1'b1; frame_tick = 1'b1; end
    @(negedge Clk) begin punch_req = 1'b0; frame_tick = 1'b0; end
    chk("same_cycle_busy", int'(busy), 1);
    chk("same_cycle_frame", int'(anim_frame), 0);
    repeat (5) tick();
    chk("pix_frame1", int'(anim_frame), 1);
    lat_px = 100; lat_py = 50; lat_left = 0;

    // Pixel vectors at anim_frame 1, inputs held steady per vector
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].px != lat_px || vecs[i].py != lat_py || vecs[i].left != lat_left) begin
        pos_x = 10'(vecs[i].px); pos_y = 10'(vecs[i].py); facing_left = 1'(vecs[i].left);
        tick();
        lat_px = vecs[i].px; lat_py = vecs[i].py; lat_left = vecs[i].left;
      end
      @(negedge Clk);
      DrawX = 10'(vecs[i].x); DrawY = 10'(vecs[i].y); rom_fix = 4'(vecs[i].rq);
      @(negedge Clk);
      chk($sformatf("v%0d_addr", i), int'(rom_addr), vecs[i].e_addr);
      repeat (2) @(negedge Clk);
      chk($sformatf("v%0d_idx", i), int'(palette_index), vecs[i].e_idx);
      chk($sformatf("v%0d_on", i), int'(sprite_on), vecs[i].e_on);
    end
    chk("pix_still_frame1", int'(anim_frame), 1);

    // Back-to-back pixels: 1-cycle address latency, 2-cycle index latency
    pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
    tick();
    DrawY = 10'd50;
    rom_stream = 1'b1;
    for (int i = 0; i < 20; i++) sx[i] = stream_x(i);
    for (int k = 0; k < 23; k++) begin
      @(negedge Clk);
      if (k >= 1 && k <= 20) begin
        dxm    = sx[k-1] - 100;
        e_addr = (dxm >= 0 && dxm < 64) ? 6144 + dxm : 0;
        chk($sformatf("s%0d_addr", k - 1), int'(rom_addr), e_addr);
      end
      if (k >= 3) begin
        dxm   = sx[k-3] - 100;
        e_idx = (dxm >= 0 && dxm < 64) ? (dxm % 16) : 0;
        chk($sformatf("s%0d_idx", k - 3), int'(palette_index), e_idx);
        chk($sformatf("s%0d_on", k - 3), int'(sprite_on), (e_idx != 0) ? 1 : 0);
      end
      if (k < 20) DrawX = 10'(sx[k]);
    end
    rom_stream = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/desppunch_anim.md
# desppunch_anim

Animation sequencer and sprite-address pipeline for the desperation-punch move. Runs the punch animation frame by frame, advancing only on video frame ticks. For every pixel it turns DrawX/DrawY into a sprite-sheet ROM address, then returns the fetched 4-bit palette index with an on/transparent flag. The output feeds the desppunch palette lookup directly, which produces the 12-bit RGB.

## Interface
Parameters:
- SPR_W, 64, sprite width in pixels
- SPR_H, 96, sprite height in pixels
- NUM_FRAMES, 4, animation frames in sheet, stored consecutively (frame-major, row-major)
- HOLD_TICKS, 5, frame_ticks each animation frame is held
- COOL_TICKS, 8, frame_ticks of cooldown after the last frame
- HIT_FRAME, 2, animation frame during which hit_active asserts
- ADDR_W, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width (15 at defaults)

Ports:
- Clk  in  1  system clock; one clock, reset is synchronous and active-high
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  single-cycle pulse at start of vertical blank
- punch_req  in  1  punch request, level, sampled every cycle
- pos_x, pos_y  in  10  sprite top-left on screen
- facing_left  in  1  1 = horizontally mirrored
- DrawX, DrawY  in  10  current pixel coordinate
- rom_addr  out  ADDR_W  sprite-sheet ROM address
- rom_q  in  4  ROM data, valid 1 cycle after rom_addr
- palette_index  out  4  index to palette stage
- sprite_on  out  1  pixel inside box and index != 0
- busy  out  1  high in PLAY or COOLDOWN
- anim_frame  out  $clog2(NUM_FRAMES)  current frame
- hit_active  out  1  high in PLAY while anim_frame == HIT_FRAME

## Operation
- FSM states: IDLE, PLAY, COOLDOWN. All state, anim_frame, hold counter and latched pos_x/pos_y/facing_left update only on cycles with frame_tick = 1, except pending.
- pending: set by punch_req in IDLE; cleared on the IDLE→PLAY transition. punch_req is ignored in PLAY and COOLDOWN.
- IDLE: anim_frame = 0. On frame_tick with (pending | punch_req): go to PLAY, anim_frame = 0, hold = 0.
- PLAY: each frame_tick increments hold. When hold == HOLD_TICKS-1: hold = 0 and anim_frame increments. If anim_frame == NUM_FRAMES-1 instead, go to COOLDOWN with cnt = 0.
- COOLDOWN: each frame_tick increments cnt. At cnt == COOL_TICKS-1, go to IDLE.
- Total move length = NUM_FRAMES*HOLD_TICKS + COOL_TICKS ticks (28 at defaults).
- Pixel path:
  - dx = DrawX - pos_x and dy = DrawY - pos_y, computed 11-bit signed against the latched position.
  - Pixel is inside when 0 ≤ dx < SPR_W and 0 ≤ dy < SPR_H. There is no wrap: a box past x = 639 is clipped.
  - col = facing_left ? SPR_W-1-dx : dx.
  - rom_addr = anim_frame*SPR_W*SPR_H + dy*SPR_W + col. Outside the box, rom_addr = 0.
- Transparency: rom_q == 0 gives sprite_on = 0 and palette_index = 0. Outside the box, sprite_on = 0 and palette_index = 0 regardless of rom_q.

## Timing
- Reset values: state IDLE, anim_frame 0, hold/cnt 0, pending 0, rom_addr 0, palette_index 0, sprite_on 0, busy 0, hit_active 0, inside-pipeline bits 0. Latched position resets to 0, facing_left to 0.
- Reset mid-animation returns to IDLE on the next edge with no residual pending.
- Pixel pipeline latency: DrawX/DrawY sampled at edge N.
  - rom_addr and in-box flag are registered at N.
  - rom_q arrives in cycle N+1.
  - palette_index and sprite_on are registered at N+2.
  - Total latency is 2 cycles, fully pipelined at one pixel per cycle.
- busy, anim_frame and hit_active change on the edge that samples frame_tick. They are therefore stable through the entire active video region, so there is no tearing.
- frame_tick and punch_req in the same cycle from IDLE: PLAY starts on that edge.

## Structure
- Shared package desppunch_pkg holds:
  - anim_state_t enum (IDLE/PLAY/COOLDOWN)
  - TRANSPARENT_IDX = 4'h0
  - SCREEN_W = 640, SCREEN_H = 480
- Sub-module desppunch_seq contains the FSM, counters, pending and position latch. The top holds the 2-stage pixel pipeline.

## Test plan
- Reset, pulse punch_req for 1 cycle between ticks → PLAY on the next frame_tick; anim_frame goes 0,1,2,3 at 5-tick spacing; COOLDOWN 8 ticks; busy high exactly 28 ticks.
- punch_req held during PLAY/COOLDOWN → ignored; no retrigger until IDLE. punch_req high in IDLE retriggers on the following tick.
- pos = (100,50), facing_left = 0, anim_frame = 1, DrawX = 103, DrawY = 52 → rom_addr = 6144+128+3 = 6275 one cycle later. rom_q = 4'h7 → palette_index 7, sprite_on 1 two cycles after the draw coordinates.
- Same pixel with facing_left = 1 → col = 60, rom_addr = 6332. DrawX = 164 (dx = 64) → sprite_on 0, palette_index 0. rom_q = 0 inside the box → sprite_on 0.
- pos_x = 600, DrawX = 10 → not inside (no wrap).
- Assert Reset during PLAY at anim_frame 2 → next cycle IDLE, anim_frame 0, hit_active 0, busy 0, sprite_on 0.
